// File: rtl/if_id_fetch_queue_pkg.sv
// Pipeline types shared by the IF/ID queue and the downstream ID/EXE pipeline registers.
package if_id_fetch_queue_pkg;

  localparam int PIPE_W = 32;

  typedef struct packed {
    logic [PIPE_W-1:0] pc;
    logic [PIPE_W-1:0] instr;
  } fetch_word_t;

endpackage

// File: rtl/if_id_fetch_queue_fifo_ram.sv
// DEPTH-entry register file holding fetch words: synchronous write, asynchronous read.
module if_id_fetch_queue_fifo_ram
  import if_id_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fetch_word_t   wdata,
  input  logic [AW-1:0] raddr,
  output fetch_word_t   rdata
);

  fetch_word_t mem_q [DEPTH];

  // NOTE: storage has no reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_id_fetch_queue.sv
// In-order IF->ID decoupling queue with full-driven IF freeze and branch flush.
module if_id_fetch_queue
  import if_id_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [PIPE_W-1:0] in_pc,
  input  logic [PIPE_W-1:0] in_instr,
  output logic              freeze_if,
  output logic              out_valid,
  output logic [PIPE_W-1:0] out_pc,
  output logic [PIPE_W-1:0] out_instr,
  input  logic              out_ready,
  output logic [AW:0]       count
);

  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, push, pop, ram_we;
  fetch_word_t   wr_word, rd_word;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
  assign push  = in_valid & ~full;
  assign pop   = ~empty & out_ready;

  // Write only on an accepted, unflushed push so X data from an idle IF never reaches storage.
  assign ram_we  = push & ~flush;
  assign wr_word = '{pc: in_pc, instr: in_instr};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  if_id_fetch_queue_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (wr_word),
    .raddr (rd_ptr_q),
    .rdata (rd_word)
  );

  assign freeze_if = full;
  assign out_valid = ~empty;
  assign out_pc    = empty ? '0 : rd_word.pc;
  assign out_instr = empty ? '0 : rd_word.instr;
  assign count     = count_q;

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed self-checking bench for if_id_fetch_queue (DEPTH=4).
module tb_if_id_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        freeze_if;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  if_id_fetch_queue #(.DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .freeze_if (freeze_if),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .count     (count)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = v ? pc : 'x;
    in_instr = v ? instr_of(pc) : 'x;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, "_pc"}, 64'(out_pc), 64'(pc));
    check({tag, "_instr"}, 64'(out_instr), 64'(instr_of(pc)));
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'h55);

    // Reset held with in_valid high: nothing may be captured.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_count", 64'(count), 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_freeze", 64'(freeze_if), 64'd0);
      check("rst_pc", 64'(out_pc), 64'd0);
    end
    drive(1'b0, 32'h0);
    rst = 1'b1;
    step();
    check("idle_count", 64'(count), 64'd0);

    // Streaming with ID always ready: one-cycle latency, count never above 1.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(4 * i));
      step();
      check_head("stream", 32'(4 * i));
      check("stream_count", 64'(count), 64'd1);
    end
    drive(1'b0, 32'h0);
    step();
    check("stream_drain_count", 64'(count), 64'd0);
    check("stream_drain_valid", 64'(out_valid), 64'd0);

    // Fill to DEPTH with ID stalled, then the fifth word waits on freeze.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i));
      step();
    end
    check("fill_count", 64'(count), 64'd4);
    check("fill_freeze", 64'(freeze_if), 64'd1);
    drive(1'b1, 32'd16);
    step();
    check("full_ignore_count", 64'(count), 64'd4);
    check_head("full_head", 32'd0);
    out_ready = 1'b1;
    step();
    check("full_pop_count", 64'(count), 64'd3);
    check_head("full_pop_head", 32'd4);
    check("full_pop_freeze", 64'(freeze_if), 64'd0);
    out_ready = 1'b0;
    step();
    check("late_push_count", 64'(count), 64'd4);
    drive(1'b0, 32'h0);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check_head("fill_drain", 32'(4 * i));
      step();
    end
    check("fill_drain_count", 64'(count), 64'd0);

    // Steady count of two across several pointer wraps.
    out_ready = 1'b0;
    drive(1'b1, 32'd0);
    step();
    drive(1'b1, 32'd4);
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(8 + 4 * i));
      check_head("wrap", 32'(4 * i));
      step();
      check("wrap_count", 64'(count), 64'd2);
    end

    // Flush beats a simultaneous push and pop.
    out_ready = 1'b0;
    drive(1'b1, 32'd48);
    step();
    check("pre_flush_count", 64'(count), 64'd3);
    flush     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'd100);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_freeze", 64'(freeze_if), 64'd0);
    check("flush_pc", 64'(out_pc), 64'd0);
    step();
    check("post_flush_count", 64'(count), 64'd0);
    drive(1'b1, 32'd200);
    step();
    check_head("target", 32'd200);
    check("target_count", 64'(count), 64'd1);

    // Asynchronous reset between edges with two entries held.
    out_ready = 1'b0;
    drive(1'b1, 32'd204);
    step();
    drive(1'b0, 32'h0);
    check("pre_areset_count", 64'(count), 64'd2);
    #2;
    rst = 1'b0;
    #1;
    check("areset_valid", 64'(out_valid), 64'd0);
    check("areset_count", 64'(count), 64'd0);
    check("areset_pc", 64'(out_pc), 64'd0);
    rst = 1'b1;
    step();
    check("areset_after_count", 64'(count), 64'd0);
    drive(1'b1, 32'd300);
    step();
    drive(1'b0, 32'h0);
    check_head("restart", 32'd300);
    check("restart_count", 64'(count), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
